// File: rtl/cone_eval_arbiter.sv
// Round-robin arbiter sharing one 3-input combinational cone among NREQ requesters.
// Operands are registered and held for SETTLE_CYC cycles before the result is captured.
module cone_eval_arbiter #(
  parameter int NREQ       = 4,
  parameter int SETTLE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [3*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [2:0]        cone_in,
  input  logic              cone_out,
  output logic [NREQ-1:0]   resp_valid,
  output logic              resp_data,
  input  logic [NREQ-1:0]   resp_ready,
  output logic              busy,
  output logic [2:0]        grant_id
);

  if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle
    $error("SETTLE_CYC must be in 1..15");
  end
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("NREQ must be in 2..8");
  end

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYC - 1);

  logic [1:0]      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [2:0]      rr_q, rr_d;
  logic [2:0]      cone_q, cone_d;
  logic [2:0]      gid_q, gid_d;
  logic [NREQ-1:0] rsv_q, rsv_d;
  logic            rsd_q, rsd_d;
  logic            busy_q, busy_d;

  logic            gnt_found;
  logic [2:0]      gnt_idx;
  logic [2:0]      gnt_data;
  logic            own_rdy;
  logic [NREQ-1:0] gid_oh;

  // First valid requester at or after rr_q, wrapping modulo NREQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_data  = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(rr_q) + k) % NREQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = 3'(idx);
        gnt_data  = req_data[3*idx +: 3];
      end
    end
  end

  always_comb begin
    own_rdy = 1'b0;
    gid_oh  = '0;
    for (int i = 0; i < NREQ; i++) begin
      gid_oh[i] = (gid_q == 3'(i));
      if (gid_q == 3'(i)) own_rdy = resp_ready[i];
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = (state_q == IDLE) && gnt_found && (gnt_idx == 3'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    cone_d  = cone_q;
    gid_d   = gid_q;
    rsv_d   = rsv_q;
    rsd_d   = rsd_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_found) begin
          cone_d  = gnt_data;
          gid_d   = gnt_idx;
          cnt_d   = CNT_INIT;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == 4'd0) begin
          rsd_d   = cone_out;
          rsv_d   = gid_oh;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        // Only the owner's ready completes the handshake.
        if (own_rdy) begin
          rsv_d   = '0;
          rr_d    = (gid_q == 3'(NREQ - 1)) ? 3'd0 : gid_q + 3'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rr_q    <= '0;
      cone_q  <= '0;
      gid_q   <= '0;
      rsv_q   <= '0;
      rsd_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      cone_q  <= cone_d;
      gid_q   <= gid_d;
      rsv_q   <= rsv_d;
      rsd_q   <= rsd_d;
      busy_q  <= busy_d;
    end
  end

  assign cone_in    = cone_q;
  assign resp_valid = rsv_q;
  assign resp_data  = rsd_q;
  assign busy       = busy_q;
  assign grant_id   = gid_q;

endmodule

// File: doc/cone_eval_arbiter.md
# cone_eval_arbiter

Round-robin scheduler that shares one instance of a 3-input, 1-output combinational evaluation cone among NREQ requesters. It registers the granted requester's operands onto the cone inputs and holds them stable for a programmable settle window. It then captures the cone output and returns it to the originating requester over a valid/ready response channel. It sits between the requester ports and a single gate-level cone netlist (inputs n_0, n_1, n_2; output n_12 style), so the cone never sees glitching or mid-evaluation operand changes.

## Interface
- NREQ, 4, number of requesters (2..8)
- SETTLE_CYC, 2, cycles cone_in is held before cone_out is sampled (1..15; 0 illegal, elaboration error)
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  NREQ  per-requester request valid
- req_data  input  3*NREQ  operands; bits [3i+2:3i] = {n_2,n_0,n_1} order fixed as {bit2,bit1,bit0} = {in2,in1,in0} for requester i
- req_ready  output  NREQ  one-hot accept strobe
- cone_in  output  3  registered operands to shared cone (bit0→in0, bit1→in1, bit2→in2)
- cone_out  input  1  cone result
- resp_valid  output  NREQ  one-hot response valid, bit = owning requester
- resp_data  output  1  captured cone result
- resp_ready  input  NREQ  per-requester response ready
- busy  output  1  high in any state other than IDLE
- grant_id  output  3  index of current/last granted requester

## Operation
- FSM states: IDLE, SETTLE, RESP.
- IDLE: grant = first i with req_valid[i], searching from rr_ptr upward modulo NREQ. req_ready[grant] = 1 combinationally; all other bits 0. If no valid, req_ready = 0, stay IDLE.
- Accept (IDLE and req_valid[g] at edge): cone_in <= req_data[g], grant_id <= g, cnt <= SETTLE_CYC-1, go SETTLE.
- SETTLE: cone_in held constant. cnt decrements each edge. At the edge where cnt == 0: resp_data <= cone_out, resp_valid[grant_id] <= 1, go RESP.
- RESP: resp_valid and resp_data held until resp_ready[grant_id] is high at an edge. On that edge: resp_valid <= 0, rr_ptr <= (grant_id+1) mod NREQ, go IDLE. resp_ready bits of other requesters are ignored.
- rr_ptr advances only on response completion. A requester dropping req_valid before acceptance is legal and has no effect.
- New requests are never accepted outside IDLE; req_ready = 0 in SETTLE/RESP.
- Reset (any state, including mid-SETTLE/RESP): state IDLE, rr_ptr 0, cnt 0, cone_in 0, resp_data 0, resp_valid 0, grant_id 0, busy 0. The in-flight transaction is dropped with no response.

## Timing
- Accept edge T: cone_in is valid after T.
- resp_valid rises at edge T+SETTLE_CYC (cone sampled after SETTLE_CYC full cycles of stable inputs).
- If resp_ready is already high when resp_valid rises, the handshake completes at edge T+SETTLE_CYC+1.
- Earliest next accept is edge T+SETTLE_CYC+2, so minimum transaction period = SETTLE_CYC+2 cycles.
- req_ready is combinational from req_valid, state and rr_ptr.
- All other outputs are registered.
- busy = (state != IDLE), registered.

## Test plan
- Bench cone model cone_out = ^cone_in. Reset, then req_valid=4'b0001, req_data[2:0]=3'b011, SETTLE_CYC=2 -> req_ready=0001 at accept edge; cone_in=011 for 2 cycles; resp_valid=0001 and resp_data=0 two edges after accept.
- All four requesters valid continuously with resp_ready=1111 -> grants in order 0,1,2,3,0.
- Each grant is spaced exactly 4 cycles apart; grant_id matches the grant sequence.
- Requester 2 holds resp_ready=0 for 5 cycles -> resp_valid=0100 and resp_data held stable. No new req_ready pulses occur; completion happens on the first edge with resp_ready[2]=1.
- Requester 1 resp_ready=1 while owner is 3 -> no completion; FSM remains in RESP.
- Assert rst_n=0 for one cycle mid-SETTLE -> all outputs return to their reset values asynchronously, and no resp_valid is ever issued for the dropped request. After release, requester 0 is granted first.
- SETTLE_CYC=1: cone_in is changed at accept, and the bench flips cone_out one cycle later -> resp_data captures the value present in that single settle cycle. Latency to resp_valid is 1 cycle.
